// File: rtl/dcache_load_tracker_pkg.sv
// Shared types for the LSU-side D-cache load tracker: bus commands,
// memory tag width and the per-miss tracking entry.
package dcache_load_tracker_pkg;

    localparam int ROB_IDX_W = 6;
    localparam int MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [MEM_TAG_W-1:0] mem_tag;
    } LD_TRACK_ENTRY;

    // Tag 0 is reserved by the memory interface to mean "no tag".
    function automatic logic tag_is_live(input logic [MEM_TAG_W-1:0] tag);
        return tag != '0;
    endfunction

endpackage

// File: rtl/ld_tag_cam.sv
// Table of outstanding load misses: parallel tag lookup, lowest-free-slot
// selection, and one allocate plus one free per cycle.
module ld_tag_cam
    import dcache_load_tracker_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [MEM_TAG_W-1:0] i_lookup_tag,
    output logic                 o_hit,
    output logic [IDX_W-1:0]     o_hit_idx,
    output logic [ROB_IDX_W-1:0] o_hit_rob_idx,
    output logic                 o_free_valid,
    output logic [IDX_W-1:0]     o_free_idx,
    input  logic                 i_alloc_en,
    input  logic [ROB_IDX_W-1:0] i_alloc_rob_idx,
    input  logic [MEM_TAG_W-1:0] i_alloc_tag,
    output logic                 o_alloc_dup,
    input  logic                 i_free_en,
    input  logic [IDX_W-1:0]     i_free_idx
);

    LD_TRACK_ENTRY r_entries [NUM_ENTRIES];

    always_comb begin
        o_hit         = 1'b0;
        o_hit_idx     = '0;
        o_hit_rob_idx = '0;
        o_alloc_dup   = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_entries[i].valid && tag_is_live(i_lookup_tag)
                    && (r_entries[i].mem_tag == i_lookup_tag)) begin
                o_hit         = 1'b1;
                o_hit_idx     = IDX_W'(i);
                o_hit_rob_idx = r_entries[i].rob_idx;
            end
            if (r_entries[i].valid && (r_entries[i].mem_tag == i_alloc_tag)) begin
                o_alloc_dup = 1'b1;
            end
        end
    end

    // Scan downward so the lowest invalid index is the one that sticks.
    always_comb begin
        o_free_valid = 1'b0;
        o_free_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_entries[i].valid) begin
                o_free_valid = 1'b1;
                o_free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (i_free_en) begin
                r_entries[i_free_idx].valid <= 1'b0;
            end
            if (i_alloc_en && o_free_valid) begin
                r_entries[o_free_idx] <= '{valid:   1'b1,
                                           rob_idx: i_alloc_rob_idx,
                                           mem_tag: i_alloc_tag};
            end
        end
    end

endmodule

// File: rtl/dcache_load_tracker.sv
// Front end between the LSU and dcache_controller: issues one op per cycle,
// answers hits directly and tracks load misses until their memory tag returns.
module dcache_load_tracker #(
    parameter int NUM_ENTRIES = 8,
    parameter int ROB_IDX_W   = dcache_load_tracker_pkg::ROB_IDX_W,
    parameter int MEM_TAG_W   = dcache_load_tracker_pkg::MEM_TAG_W,
    parameter int CNT_W       = $clog2(NUM_ENTRIES + 1),
    parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                lsu_req_valid,
    input  dcache_load_tracker_pkg::BUS_COMMAND lsu_req_cmd,
    input  logic [63:0]                         lsu_req_addr,
    input  logic [63:0]                         lsu_req_data,
    input  logic [ROB_IDX_W-1:0]                lsu_req_rob_idx,
    output logic                                lsu_req_ready,
    output dcache_load_tracker_pkg::BUS_COMMAND proc2Dcache_command,
    output logic [63:0]                         proc2Dcache_addr,
    output logic [63:0]                         proc2Dcache_data,
    input  logic [63:0]                         Dcache_data_out,
    input  logic                                unanswered_miss,
    input  logic [MEM_TAG_W-1:0]                Dcache2proc_response,
    input  logic [MEM_TAG_W-1:0]                Dcache2proc_tag,
    input  logic [63:0]                         Dmem2proc_data,
    output logic                                ld_done_valid,
    output logic [ROB_IDX_W-1:0]                ld_done_rob_idx,
    output logic [63:0]                         ld_done_data,
    output logic                                st_done_valid,
    output logic [ROB_IDX_W-1:0]                st_done_rob_idx,
    output logic                                tracker_full,
    output logic [CNT_W-1:0]                    outstanding_cnt
);

    import dcache_load_tracker_pkg::*;

    logic                 w_is_load;
    logic                 w_is_store;
    logic                 w_return_match;
    logic [IDX_W-1:0]     w_match_idx;
    logic [ROB_IDX_W-1:0] w_match_rob_idx;
    logic                 w_free_valid;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_alloc_dup;
    logic                 w_hit_accept;
    logic                 w_alloc;
    logic                 w_st_accept;

    logic                 r_ld_done_valid;
    logic [ROB_IDX_W-1:0] r_ld_done_rob_idx;
    logic [63:0]          r_ld_done_data;
    logic                 r_st_done_valid;
    logic [ROB_IDX_W-1:0] r_st_done_rob_idx;
    logic [CNT_W-1:0]     r_count;
    logic                 r_full;

    ld_tag_cam #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_cam (
        .clock           (clock),
        .reset           (reset),
        .i_lookup_tag    (Dcache2proc_tag),
        .o_hit           (w_return_match),
        .o_hit_idx       (w_match_idx),
        .o_hit_rob_idx   (w_match_rob_idx),
        .o_free_valid    (w_free_valid),
        .o_free_idx      (w_free_idx),
        .i_alloc_en      (w_alloc),
        .i_alloc_rob_idx (lsu_req_rob_idx),
        .i_alloc_tag     (Dcache2proc_response),
        .o_alloc_dup     (w_alloc_dup),
        .i_free_en       (w_return_match),
        .i_free_idx      (w_match_idx)
    );

    // Fullness comes from the registered count, so a slot freed this cycle
    // cannot be handed out until the next one.
    always_comb begin
        w_is_load    = lsu_req_valid && (lsu_req_cmd == BUS_LOAD);
        w_is_store   = lsu_req_valid && (lsu_req_cmd == BUS_STORE);
        w_hit_accept = w_is_load && !r_full && !unanswered_miss && !w_return_match;
        w_alloc      = w_is_load && !r_full && unanswered_miss
                       && (Dcache2proc_response != '0) && w_free_valid;
        w_st_accept  = w_is_store && !unanswered_miss;
    end

    always_comb begin
        proc2Dcache_command = BUS_NONE;
        if (lsu_req_valid && !(w_is_load && r_full)) begin
            proc2Dcache_command = lsu_req_cmd;
        end
        proc2Dcache_addr = lsu_req_addr;
        proc2Dcache_data = lsu_req_data;
        lsu_req_ready    = w_hit_accept || w_alloc || w_st_accept;
    end

    // A returning miss has priority over a hit; the hit was refused above,
    // so at most one load completes per cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ld_done_valid   <= 1'b0;
            r_ld_done_rob_idx <= '0;
            r_ld_done_data    <= '0;
            r_st_done_valid   <= 1'b0;
            r_st_done_rob_idx <= '0;
        end else begin
            r_ld_done_valid <= w_return_match || w_hit_accept;
            if (w_return_match) begin
                r_ld_done_rob_idx <= w_match_rob_idx;
                r_ld_done_data    <= Dmem2proc_data;
            end else if (w_hit_accept) begin
                r_ld_done_rob_idx <= lsu_req_rob_idx;
                r_ld_done_data    <= Dcache_data_out;
            end
            r_st_done_valid <= w_st_accept;
            if (w_st_accept) begin
                r_st_done_rob_idx <= lsu_req_rob_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            case ({w_alloc, w_return_match})
                2'b10: begin
                    r_count <= r_count + 1'b1;
                    r_full  <= (r_count + 1'b1) == CNT_W'(NUM_ENTRIES);
                end
                2'b01: begin
                    r_count <= r_count - 1'b1;
                    r_full  <= 1'b0;
                end
                default: begin
                    r_count <= r_count;
                    r_full  <= r_full;
                end
            endcase
        end
    end

    assign ld_done_valid   = r_ld_done_valid;
    assign ld_done_rob_idx = r_ld_done_rob_idx;
    assign ld_done_data    = r_ld_done_data;
    assign st_done_valid   = r_st_done_valid;
    assign st_done_rob_idx = r_st_done_rob_idx;
    assign tracker_full    = r_full;
    assign outstanding_cnt = r_count;

    a_alloc_tag_unique: assert property (@(posedge clock) disable iff (!reset)
        w_alloc |-> !w_alloc_dup);

    a_single_load_completion: assert property (@(posedge clock) disable iff (!reset)
        !(w_return_match && w_hit_accept));

    a_full_matches_count: assert property (@(posedge clock) disable iff (!reset)
        r_full == (r_count == CNT_W'(NUM_ENTRIES)));

endmodule

// File: tb/tb_dcache_load_tracker.sv
// Directed bench for dcache_load_tracker; completions are checked by a
// scoreboard monitor against expectations queued when ops are issued.
module tb_dcache_load_tracker;

   import dcache_load_tracker_pkg::*;

   logic        clock;
   logic        reset;
   logic        lsu_req_valid;
   BUS_COMMAND  lsu_req_cmd;
   logic [63:0] lsu_req_addr;
   logic [63:0] lsu_req_data;
   logic [5:0]  lsu_req_rob_idx;
   logic        lsu_req_ready;
   BUS_COMMAND  proc2Dcache_command;
   logic [63:0] proc2Dcache_addr;
   logic [63:0] proc2Dcache_data;
   logic [63:0] Dcache_data_out;
   logic        unanswered_miss;
   logic [3:0]  Dcache2proc_response;
   logic [3:0]  Dcache2proc_tag;
   logic [63:0] Dmem2proc_data;
   logic        ld_done_valid;
   logic [5:0]  ld_done_rob_idx;
   logic [63:0] ld_done_data;
   logic        st_done_valid;
   logic [5:0]  st_done_rob_idx;
   logic        tracker_full;
   logic [3:0]  outstanding_cnt;

   typedef struct {
      logic [5:0]  rob;
      logic [63:0] data;
   } ldExp_t;

   ldExp_t     ldExpQ[$];
   logic [5:0] stExpQ[$];
   int         testCount = 0;
   int         failCount = 0;

   dcache_load_tracker dut (
      .clock                (clock),
      .reset                (reset),
      .lsu_req_valid        (lsu_req_valid),
      .lsu_req_cmd          (lsu_req_cmd),
      .lsu_req_addr         (lsu_req_addr),
      .lsu_req_data         (lsu_req_data),
      .lsu_req_rob_idx      (lsu_req_rob_idx),
      .lsu_req_ready        (lsu_req_ready),
      .proc2Dcache_command  (proc2Dcache_command),
      .proc2Dcache_addr     (proc2Dcache_addr),
      .proc2Dcache_data     (proc2Dcache_data),
      .Dcache_data_out      (Dcache_data_out),
      .unanswered_miss      (unanswered_miss),
      .Dcache2proc_response (Dcache2proc_response),
      .Dcache2proc_tag      (Dcache2proc_tag),
      .Dmem2proc_data       (Dmem2proc_data),
      .ld_done_valid        (ld_done_valid),
      .ld_done_rob_idx      (ld_done_rob_idx),
      .ld_done_data         (ld_done_data),
      .st_done_valid        (st_done_valid),
      .st_done_rob_idx      (st_done_rob_idx),
      .tracker_full         (tracker_full),
      .outstanding_cnt      (outstanding_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one cycle's worth of inputs just after a falling edge and lets
   // the combinational outputs settle before anything is inspected.
   task automatic applyStimulus(input logic v, input BUS_COMMAND c, input logic [5:0] rob,
                                input logic miss, input logic [3:0] resp, input logic [3:0] tag,
                                input logic [63:0] mdata, input logic [63:0] ddata);
      lsu_req_valid        = v;
      lsu_req_cmd          = c;
      lsu_req_rob_idx      = rob;
      lsu_req_addr         = 64'h100 + {55'd0, rob, 3'b000};
      lsu_req_data         = {58'd0, rob} ^ 64'h5A5A_0000_0000_0000;
      unanswered_miss      = miss;
      Dcache2proc_response = resp;
      Dcache2proc_tag      = tag;
      Dmem2proc_data       = mdata;
      Dcache_data_out      = ddata;
      #1;
   endtask

   task automatic idle(input logic [3:0] tag, input logic [63:0] mdata);
      applyStimulus(1'b0, BUS_NONE, 6'd0, 1'b0, 4'd0, tag, mdata, 64'd0);
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic pushLoad(input logic [5:0] rob, input logic [63:0] data);
      ldExp_t e;
      e.rob  = rob;
      e.data = data;
      ldExpQ.push_back(e);
   endtask

   // Scoreboard monitor: every completion pulse must match the oldest
   // expectation, and a pulse with nothing expected is itself an error.
   always @(negedge clock) begin
      if (reset) begin
         if (ld_done_valid) begin
            if (ldExpQ.size() == 0) begin
               testCount++;
               failCount++;
               $display("[TB] FAIL ld_unexpected: got rob %0d data 0x%0h, expected no completion",
                        ld_done_rob_idx, ld_done_data);
            end else begin
               ldExp_t e;
               e = ldExpQ.pop_front();
               checkOutput("ld_done_rob_idx", {58'd0, ld_done_rob_idx}, {58'd0, e.rob});
               checkOutput("ld_done_data", ld_done_data, e.data);
            end
         end
         if (st_done_valid) begin
            if (stExpQ.size() == 0) begin
               testCount++;
               failCount++;
               $display("[TB] FAIL st_unexpected: got rob %0d, expected no completion", st_done_rob_idx);
            end else begin
               logic [5:0] r;
               r = stExpQ.pop_front();
               checkOutput("st_done_rob_idx", {58'd0, st_done_rob_idx}, {58'd0, r});
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      idle(4'd0, 64'd0);
      repeat (2) @(negedge clock);
      checkOutput("rst_ld_valid", {63'd0, ld_done_valid}, 64'd0);
      checkOutput("rst_st_valid", {63'd0, st_done_valid}, 64'd0);
      checkOutput("rst_ld_data", ld_done_data, 64'd0);
      checkOutput("rst_cnt", {60'd0, outstanding_cnt}, 64'd0);
      checkOutput("rst_full", {63'd0, tracker_full}, 64'd0);
      reset = 1'b1;
      tick();

      // Plain hit answered the next cycle
      applyStimulus(1'b1, BUS_LOAD, 6'd5, 1'b0, 4'd0, 4'd0, 64'd0, 64'hAB);
      checkOutput("hit_ready", {63'd0, lsu_req_ready}, 64'd1);
      checkOutput("hit_cmd", {62'd0, proc2Dcache_command}, {62'd0, BUS_LOAD});
      checkOutput("hit_addr", proc2Dcache_addr, 64'h128);
      pushLoad(6'd5, 64'hAB);
      tick();

      // Miss allocated, then returned by its tag
      applyStimulus(1'b1, BUS_LOAD, 6'd7, 1'b1, 4'd3, 4'd0, 64'd0, 64'd0);
      checkOutput("miss_ready", {63'd0, lsu_req_ready}, 64'd1);
      tick();
      checkOutput("miss_cnt", {60'd0, outstanding_cnt}, 64'd1);
      idle(4'd3, 64'hCAFE);
      pushLoad(6'd7, 64'hCAFE);
      tick();
      checkOutput("return_cnt", {60'd0, outstanding_cnt}, 64'd0);

      // Memory busy twice, then tag 9 granted
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, BUS_LOAD, 6'd10, 1'b1, (i == 2) ? 4'd9 : 4'd0, 4'd0, 64'd0, 64'd0);
         checkOutput($sformatf("busy_ready_%0d", i), {63'd0, lsu_req_ready}, (i == 2) ? 64'd1 : 64'd0);
         tick();
      end
      checkOutput("busy_cnt", {60'd0, outstanding_cnt}, 64'd1);
      idle(4'd9, 64'h99);
      pushLoad(6'd10, 64'h99);
      tick();

      // Fill all eight entries with tags 1..8
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, BUS_LOAD, 6'(20 + i), 1'b1, 4'(i), 4'd0, 64'd0, 64'd0);
         checkOutput($sformatf("fill_ready_%0d", i), {63'd0, lsu_req_ready}, 64'd1);
         tick();
      end
      checkOutput("fill_cnt", {60'd0, outstanding_cnt}, 64'd8);
      checkOutput("fill_full", {63'd0, tracker_full}, 64'd1);
      applyStimulus(1'b1, BUS_LOAD, 6'd30, 1'b0, 4'd0, 4'd0, 64'd0, 64'h30);
      checkOutput("full_load_cmd", {62'd0, proc2Dcache_command}, {62'd0, BUS_NONE});
      checkOutput("full_load_ready", {63'd0, lsu_req_ready}, 64'd0);
      applyStimulus(1'b1, BUS_STORE, 6'd31, 1'b0, 4'd0, 4'd0, 64'd0, 64'd0);
      checkOutput("full_store_ready", {63'd0, lsu_req_ready}, 64'd1);
      checkOutput("full_store_cmd", {62'd0, proc2Dcache_command}, {62'd0, BUS_STORE});
      stExpQ.push_back(6'd31);
      tick();
      applyStimulus(1'b1, BUS_STORE, 6'd32, 1'b1, 4'd0, 4'd0, 64'd0, 64'd0);
      checkOutput("miss_store_ready", {63'd0, lsu_req_ready}, 64'd0);
      tick();

      // Hit colliding with returns: tag 1 while full, tag 2 once not full
      applyStimulus(1'b1, BUS_LOAD, 6'd40, 1'b0, 4'd0, 4'd1, 64'h1111, 64'h4040);
      checkOutput("collide_full_ready", {63'd0, lsu_req_ready}, 64'd0);
      pushLoad(6'd21, 64'h1111);
      tick();
      checkOutput("collide_cnt", {60'd0, outstanding_cnt}, 64'd7);
      checkOutput("collide_full", {63'd0, tracker_full}, 64'd0);
      applyStimulus(1'b1, BUS_LOAD, 6'd40, 1'b0, 4'd0, 4'd2, 64'h2222, 64'h4040);
      checkOutput("collide_ready", {63'd0, lsu_req_ready}, 64'd0);
      pushLoad(6'd22, 64'h2222);
      tick();
      applyStimulus(1'b1, BUS_LOAD, 6'd40, 1'b0, 4'd0, 4'd0, 64'd0, 64'h4040);
      checkOutput("retry_ready", {63'd0, lsu_req_ready}, 64'd1);
      pushLoad(6'd40, 64'h4040);
      tick();

      // Free and allocate in the same cycle keep the count steady
      applyStimulus(1'b1, BUS_LOAD, 6'd41, 1'b1, 4'd12, 4'd3, 64'h3333, 64'd0);
      checkOutput("swap_ready", {63'd0, lsu_req_ready}, 64'd1);
      pushLoad(6'd23, 64'h3333);
      tick();
      checkOutput("swap_cnt", {60'd0, outstanding_cnt}, 64'd6);

      // Refill to full; a return while full cannot be reused by a same-cycle miss
      applyStimulus(1'b1, BUS_LOAD, 6'd42, 1'b1, 4'd13, 4'd0, 64'd0, 64'd0);
      tick();
      applyStimulus(1'b1, BUS_LOAD, 6'd43, 1'b1, 4'd14, 4'd0, 64'd0, 64'd0);
      tick();
      checkOutput("refill_full", {63'd0, tracker_full}, 64'd1);
      applyStimulus(1'b1, BUS_LOAD, 6'd44, 1'b1, 4'd15, 4'd4, 64'h4444, 64'd0);
      checkOutput("full_swap_ready", {63'd0, lsu_req_ready}, 64'd0);
      pushLoad(6'd24, 64'h4444);
      tick();
      checkOutput("full_swap_cnt", {60'd0, outstanding_cnt}, 64'd7);

      // Unknown nonzero tag is ignored
      idle(4'd11, 64'hBAD);
      tick();
      checkOutput("stray_tag_cnt", {60'd0, outstanding_cnt}, 64'd7);

      // Reset with misses outstanding; stale returns afterwards are dropped
      idle(4'd0, 64'd0);
      reset = 1'b0;
      #1;
      checkOutput("midrst_cnt", {60'd0, outstanding_cnt}, 64'd0);
      checkOutput("midrst_full", {63'd0, tracker_full}, 64'd0);
      checkOutput("midrst_ld_valid", {63'd0, ld_done_valid}, 64'd0);
      tick();
      reset = 1'b1;
      idle(4'd5, 64'h5555);
      tick();
      idle(4'd2, 64'h2222);
      tick();
      checkOutput("stale_cnt", {60'd0, outstanding_cnt}, 64'd0);
      applyStimulus(1'b1, BUS_LOAD, 6'd50, 1'b0, 4'd0, 4'd0, 64'd0, 64'h5050);
      checkOutput("post_rst_ready", {63'd0, lsu_req_ready}, 64'd1);
      pushLoad(6'd50, 64'h5050);
      tick();

      idle(4'd0, 64'd0);
      repeat (3) tick();
      checkOutput("ld_queue_drained", 64'(ldExpQ.size()), 64'd0);
      checkOutput("st_queue_drained", 64'(stExpQ.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
